// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Index width for owner/rr_ptr; never narrower than one bit so NREQ=1 still has a port.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_pick.sv
// Combinational round-robin picker: first active bit at or above rr_ptr, wrapping to 0.
module reg_write_arbiter_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] act,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   index,
  output logic            any
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
    win   = '0;
    index = '0;
    any   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (int'(rr_ptr) + off) % NREQ;
      if (!any && act[idx]) begin
        any      = 1'b1;
        index    = PW'(idx);
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one N-bit holding register between NREQ requesters,
// with an optional lock that lets the current winner own the register for a burst.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N    = 100,
  parameter int NREQ = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               clr_req,
  input  logic [NREQ-1:0]               lock,
  input  logic [NREQ*N-1:0]             wdata,
  output logic [NREQ-1:0]               gnt,
  output logic [N-1:0]                  reg_data,
  output logic                          reg_enable,
  output logic                          reg_clear,
  output logic                          busy,
  output logic [clog2_min1(NREQ)-1:0]   owner
);

  localparam int PW = clog2_min1(NREQ);

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, ptr_nxt;
  logic [NREQ-1:0] act, act_m;
  logic [NREQ-1:0] pick_win;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] gnt_nxt;
  logic [N-1:0]    data_nxt;
  logic            en_nxt, clr_nxt;
  logic [PW-1:0]   owner_nxt;
  logic            svc;
  logic [PW-1:0]   svc_idx;

  // A requester just granted is ignored for one cycle so it has time to drop its
  // request; the lock owner is exempt so bursts can run back-to-back.
  always_comb begin
    act   = req | clr_req;
    act_m = act & ~gnt;
    if (state == ST_LOCKED) act_m[owner] = act[owner];
  end

  reg_write_arbiter_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .act    (act_m),
    .rr_ptr (rr_ptr),
    .win    (pick_win),
    .index  (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    gnt_nxt   = '0;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    data_nxt  = reg_data;
    owner_nxt = owner;
    svc       = 1'b0;
    svc_idx   = owner;

    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          svc     = 1'b1;
          svc_idx = pick_idx;
          gnt_nxt = pick_win;
          ptr_nxt = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
          if (lock[pick_idx]) state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Releasing the lock costs one cycle with no grant, even if the owner still requests.
        if (!lock[owner]) begin
          state_nxt = ST_IDLE;
        end else if (act_m[owner]) begin
          svc            = 1'b1;
          svc_idx        = owner;
          gnt_nxt[owner] = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (svc) begin
      owner_nxt = svc_idx;
      if (clr_req[svc_idx]) begin
        clr_nxt = 1'b1;
      end else begin
        en_nxt   = 1'b1;
        data_nxt = wdata[svc_idx*N +: N];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      reg_data   <= '0;
      reg_enable <= 1'b0;
      reg_clear  <= 1'b0;
      busy       <= 1'b0;
      owner      <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= ptr_nxt;
      gnt        <= gnt_nxt;
      reg_data   <= data_nxt;
      reg_enable <= en_nxt;
      reg_clear  <= clr_nxt;
      busy       <= (state_nxt == ST_LOCKED);
      owner      <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scenarios plus randomized traffic for reg_write_arbiter, checked against a behavioural model.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int PW   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req, clr_req, lock;
  logic [NREQ*N-1:0]   wdata;
  logic [NREQ-1:0]     gnt;
  logic [N-1:0]        reg_data;
  logic                reg_enable, reg_clear, busy;
  logic [PW-1:0]       owner;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the outputs must be after the next edge.
  bit              m_locked;
  int              m_owner, m_ptr;
  logic [NREQ-1:0] m_gnt;
  logic [N-1:0]    m_data;
  bit              m_en, m_clr;

  reg_write_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .clr_req    (clr_req),
    .lock       (lock),
    .wdata      (wdata),
    .gnt        (gnt),
    .reg_data   (reg_data),
    .reg_enable (reg_enable),
    .reg_clear  (reg_clear),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int k);
    m_gnt   = '0;
    m_gnt[k] = 1'b1;
    m_owner = k;
    if (clr_req[k]) m_clr = 1'b1;
    else begin
      m_en   = 1'b1;
      m_data = wdata[k*N +: N];
    end
  endtask

  // One clock of the arbitration rules, applied to the current inputs.
  task automatic model_step();
    logic [NREQ-1:0] act;
    int  w;
    bit  found;
    if (reset) begin
      m_locked = 0; m_owner = 0; m_ptr = 0;
      m_gnt = '0; m_data = '0; m_en = 0; m_clr = 0;
      return;
    end
    act = req | clr_req;
    for (int i = 0; i < NREQ; i++)
      if (m_gnt[i] && !(m_locked && i == m_owner)) act[i] = 1'b0;
    m_gnt = '0; m_en = 0; m_clr = 0;
    if (m_locked) begin
      if (!lock[m_owner]) m_locked = 0;
      else if (act[m_owner]) serve(m_owner);
    end else begin
      found = 0;
      w     = 0;
      for (int off = 0; off < NREQ; off++) begin
        if (!found && act[(m_ptr + off) % NREQ]) begin
          found = 1;
          w     = (m_ptr + off) % NREQ;
        end
      end
      if (found) begin
        serve(w);
        m_ptr = (w + 1) % NREQ;
        if (lock[w]) m_locked = 1;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".gnt"},    64'(gnt),        64'(m_gnt));
    check({tag, ".en"},     64'(reg_enable), 64'(m_en));
    check({tag, ".clr"},    64'(reg_clear),  64'(m_clr));
    check({tag, ".data"},   64'(reg_data),   64'(m_data));
    check({tag, ".busy"},   64'(busy),       64'(m_locked));
    check({tag, ".owner"},  64'(owner),      64'(m_owner));
  endtask

  initial begin
    reset = 1'b1; req = '1; clr_req = '0; lock = '0;
    wdata = {$urandom, $urandom} >> (64 - NREQ*N);

    // 1: reset with all requesters active
    tick("t1a");
    tick("t1b");
    check("t1_gnt", 64'(gnt), 64'd0);
    check("t1_owner", 64'(owner), 64'd0);

    // 2: full round, each requester drops on its grant
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tick("t2");
      check("t2_gnt_seq", 64'(gnt), 64'(1 << i));
      check("t2_data", 64'(reg_data), 64'(wdata[i*N +: N]));
      req = req & ~gnt;
    end

    // 3: req[2] held three cycles -> write, masked, write again
    wdata[2*N +: N] = 8'hA5;
    req = 4'b0100;
    tick("t3a");
    check("t3_first_en", 64'(reg_enable), 64'd1);
    check("t3_first_data", 64'(reg_data), 64'hA5);
    tick("t3b");
    check("t3_masked_en", 64'(reg_enable), 64'd0);
    tick("t3c");
    check("t3_second_en", 64'(reg_enable), 64'd1);
    req = '0;
    tick("t3d");

    // 4: clear wins over write for the same requester
    req = 4'b0010; clr_req = 4'b0010;
    tick("t4");
    check("t4_gnt", 64'(gnt), 64'b0010);
    check("t4_clr", 64'(reg_clear), 64'd1);
    check("t4_en", 64'(reg_enable), 64'd0);
    req = '0; clr_req = '0;
    tick("t4b");

    // 5: locked burst by requester 3 while requester 0 waits
    req = 4'b1001; lock = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick("t5");
      check("t5_burst_gnt", 64'(gnt), 64'b1000);
      check("t5_busy", 64'(busy), 64'd1);
    end
    lock = '0; req = 4'b0001;
    tick("t5_release");
    check("t5_idle_gnt", 64'(gnt), 64'd0);
    tick("t5_next");
    check("t5_next_gnt", 64'(gnt), 64'b0001);
    req = '0;
    tick("t5_end");

    // 6: reset in the middle of a burst
    req = 4'b1001; lock = 4'b1000;
    tick("t6a");
    tick("t6b");
    reset = 1'b1;
    tick("t6_rst");
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_gnt", 64'(gnt), 64'd0);
    reset = 1'b0; lock = '0; req = 4'b1111;
    tick("t6_after");
    check("t6_first_gnt", 64'(gnt), 64'b0001);

    // Randomized traffic including occasional reset
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 59) == 0);
      req     = NREQ'($urandom);
      clr_req = NREQ'($urandom & $urandom & $urandom);
      lock    = NREQ'($urandom | $urandom);
      wdata   = {$urandom, $urandom} >> (64 - NREQ*N);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
